// File: rtl/div_32_seq_if.sv
// Request/response bundle for the 32-bit sequential divider.
// The master drives the operands and start; the slave returns results and status.
interface div_32_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (output start, a, b, input q, r, busy, done, div_zero);
  modport slave  (input start, a, b, output q, r, busy, done, div_zero);
endinterface

// File: rtl/div_32_seq.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle.
// A zero divisor skips iteration and reports q=all-ones, r=a, div_zero=1.
module div_32_seq (
  input  logic         clk,
  input  logic         reset,
  div_32_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dz_q, dz_d;

  // The stored remainder is always below the divisor, so 32 bits hold it;
  // the shifted value and the trial subtraction need the full 33 bits.
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] quo_nx;
  logic [31:0] rem_nx;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
    quo_nx  = {quo_q[30:0], ~trial[32]};
    rem_nx  = trial[32] ? shifted[31:0] : trial[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.b != 32'd0) begin
            quo_d   = bus.a;
            dvs_d   = bus.b;
            rem_d   = '0;
            cnt_d   = 5'd31;
            dz_d    = 1'b0;
            state_d = RUN;
          end else begin
            q_d     = 32'hFFFF_FFFF;
            r_d     = bus.a;
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q - 5'd1;
        // Results become visible only when the last bit has been resolved.
        if (cnt_q == 5'd0) begin
          cnt_d   = '0;
          q_d     = quo_nx;
          r_d     = rem_nx;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == DONE);
    bus.q        = q_q;
    bus.r        = r_q;
    bus.div_zero = dz_q;
  end

endmodule

// File: tb/tb_div_32_seq.sv
// Randomised and directed checks of div_32_seq against plain-arithmetic division.
module tb_div_32_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_32_seq_if bus ();

  div_32_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one division and check it end to end. exp_wait is the number of
  // edges until the request is accepted; tail consumes the cycle after done.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input int exp_wait, input bit repulse, input bit tail);
    logic [31:0] eq, er, q0, r0;
    bit          ez;
    int          wait_c, lat, busy_c, changes;
    ez = (bv == 32'd0);
    eq = ez ? 32'hFFFF_FFFF : av / bv;
    er = ez ? av : av % bv;
    q0 = bus.q;
    r0 = bus.r;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    wait_c    = 0;
    do begin
      @(posedge clk); #1;
      wait_c++;
    end while (!bus.busy && !bus.done && wait_c < 5);
    bus.start = 1'b0;
    chk("accept_wait", wait_c, exp_wait);
    lat     = 1;
    busy_c  = bus.busy ? 1 : 0;
    changes = 0;
    while (!bus.done && lat < 40) begin
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.start = (repulse && lat == 10);
      if (bus.q !== q0 || bus.r !== r0) changes++;
      @(posedge clk); #1;
      lat++;
      if (bus.busy) busy_c++;
    end
    bus.start = 1'b0;
    chk("latency", lat, ez ? 1 : 33);
    chk("busy_cycles", busy_c, ez ? 0 : 32);
    chk("q", bus.q, eq);
    chk("r", bus.r, er);
    chk("div_zero", bus.div_zero, ez);
    chk("busy_at_done", bus.busy, 0);
    if (!ez) chk("no_intermediate", changes, 0);
    n_txn++;
    $display("txn %0d a=%08h b=%08h q=%08h r=%08h dz=%0d lat=%0d",
             n_txn, av, bv, bus.q, bus.r, bus.div_zero, lat);
    if (tail) begin
      @(posedge clk); #1;
      chk("done_pulse_len", bus.done, 0);
    end
  endtask

  initial begin
    int next_wait;
    int seen_done;
    logic [31:0] ra, rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", bus.q, 0);
    chk("rst_r", bus.r, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(32'd15, 32'd2, 1, 1'b0, 1'b1);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b1);
    run_op(32'd5, 32'd9, 1, 1'b0, 1'b1);
    run_op(32'd0, 32'd3, 1, 1'b0, 1'b1);
    run_op(32'd100, 32'd0, 1, 1'b0, 1'b1);
    run_op(32'd77, 32'd1, 1, 1'b0, 1'b1);
    run_op(32'd1234567, 32'd89, 1, 1'b1, 1'b1);
    // start held from the done cycle: ignored in DONE, accepted one edge later
    run_op(32'hDEAD_BEEF, 32'h0001_0003, 1, 1'b0, 1'b0);
    run_op(32'hCAFE_F00D, 32'hFFFF_FFFF, 2, 1'b0, 1'b1);

    // Abort mid-RUN with an asynchronous reset
    bus.start = 1'b1;
    bus.a     = 32'd12345;
    bus.b     = 32'd77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("busy_before_abort", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_q", bus.q, 0);
    chk("abort_r", bus.r, 0);
    chk("abort_busy", bus.busy, 0);
    @(posedge clk); #1;
    reset     = 1'b0;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    run_op(32'd1000, 32'd7, 1, 1'b0, 1'b1);

    // Reset asserted together with start drops the request
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", bus.busy, 0);
    chk("rst_start_done", bus.done, 0);
    @(posedge clk); #1;
    chk("rst_start_idle", bus.busy, 0);

    next_wait = 1;
    for (int i = 0; i < 1500; i++) begin
      bit tail;
      ra = $urandom;
      rb = $urandom;
      if ((i % 4) == 1) rb = rb >> $urandom_range(31, 1);
      if ((i % 7) == 3) ra = ra >> $urandom_range(31, 1);
      if (rb == 32'd0) rb = 32'd1;
      tail = ((i % 2) == 0);
      run_op(ra, rb, next_wait, 1'b0, tail);
      next_wait = tail ? 1 : 2;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
